inst_fetch_unit: RTL and testbench

Fetch stage of the MIPS core: holds the program counter, fetches one 32-bit instruction per transaction from instruction memory through a variable-latency request/response handshake, and latches it into an instruction register. It splits the latched instruction into decode fields, including the Immediate16 that feeds the immediate extender and the JumpIndex used for jumps. On each downstream handshake it computes the next PC (sequential, branch, jump, register jump).

---
 rtl/inst_fetch_unit.sv | 114 +++++++++++
 tb/tb_inst_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// MIPS fetch stage: owns the PC, fetches one instruction per request/response
// transaction, holds it for decode and computes the next PC at the handshake.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  output logic        InstValid,
  input  logic        InstReady,
  input  logic [1:0]  NPCOp,
  input  logic        BranchTaken,
  input  logic [31:0] RegTarget,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic [5:0]  Opcode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [15:0] Immediate16,
  output logic [25:0] JumpIndex,
  output logic        AddrError,
  output logic [2:0]  dbg_state
);

  // Handshakes:
  //   fetch:      IMemReq is a one-cycle pulse in REQ; the response is taken on
  //               any cycle in WAIT where IMemValid=1 (IMemValid elsewhere is ignored).
  //   downstream: a transfer happens on a rising edge where InstValid && InstReady;
  //               NPCOp/BranchTaken/RegTarget are sampled on that same edge.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        misaligned;
  logic        handshake;
  logic        resp_take;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign misaligned = (PC[1:0] != 2'b00);
  assign handshake  = (state == HOLD) && InstReady;
  assign resp_take  = (state == WAIT) && IMemValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     state_nxt = misaligned ? FAULT : WAIT;
      WAIT:    if (IMemValid) state_nxt = HOLD;
      HOLD:    if (InstReady) state_nxt = REQ;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  assign IMemReq   = (state == REQ) && !misaligned;
  assign IMemAddr  = PC;
  assign InstValid = (state == HOLD);
  assign AddrError = (state == FAULT);
  assign dbg_state = state;

  // Next-PC selection; register jumps pass through so a bad target faults in REQ.
  assign pc4    = PC + 32'd4;
  assign br_off = {{14{Immediate16[15]}}, Immediate16, 2'b00};

  always_comb begin
    next_pc = pc4;
    case (NPCOp)
      2'b00: next_pc = pc4;
      2'b01: next_pc = BranchTaken ? (pc4 + br_off) : pc4;
      2'b10: next_pc = {pc4[31:28], JumpIndex, 2'b00};
      2'b11: next_pc = RegTarget;
      default: next_pc = pc4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC          <= RESET_PC;
      Instruction <= 32'h0;
    end else begin
      if (resp_take) Instruction <= IMemData;
      if (handshake) PC          <= next_pc;
    end
  end

  assign Opcode      = Instruction[31:26];
  assign Rs          = Instruction[25:21];
  assign Rt          = Instruction[20:16];
  assign Rd          = Instruction[15:11];
  assign Shamt       = Instruction[10:6];
  assign Funct       = Instruction[5:0];
  assign Immediate16 = Instruction[15:0];
  assign JumpIndex   = Instruction[25:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: variable-latency memory responder,
// sequential/branch/jump/register-jump flow, fault, backpressure, async reset.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic        InstValid;
  logic        InstReady;
  logic [1:0]  NPCOp;
  logic        BranchTaken;
  logic [31:0] RegTarget;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [5:0]  Opcode;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [5:0]  Funct;
  logic [15:0] Immediate16;
  logic [25:0] JumpIndex;
  logic        AddrError;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  int          lat_cfg = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          spurious = 1'b0;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemValid(IMemValid), .IMemData(IMemData),
    .InstValid(InstValid), .InstReady(InstReady),
    .NPCOp(NPCOp), .BranchTaken(BranchTaken), .RegTarget(RegTarget),
    .PC(PC), .Instruction(Instruction),
    .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
    .Immediate16(Immediate16), .JumpIndex(JumpIndex),
    .AddrError(AddrError), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory responder: IMemValid arrives lat_cfg cycles after the request cycle
  initial begin
    IMemValid = 1'b0;
    IMemData  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      IMemValid = 1'b0;
      if (rst) begin
        pend_cnt = 0;
      end else begin
        if (spurious) begin
          IMemValid = 1'b1;
          IMemData  = 32'hDEAD_BEEF;
          spurious  = 1'b0;
        end
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            IMemValid = 1'b1;
            IMemData  = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
          end
        end
        if (IMemReq) begin
          pend_addr = IMemAddr;
          pend_cnt  = lat_cfg;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},    PC,          32'h0000_3000);
    check({tag, "_ir"},    Instruction, 32'h0);
    check({tag, "_req"},   IMemReq,     1'b0);
    check({tag, "_addr"},  IMemAddr,    32'h0000_3000);
    check({tag, "_valid"}, InstValid,   1'b0);
    check({tag, "_aerr"},  AddrError,   1'b0);
    check({tag, "_state"}, dbg_state,   3'd0);
  endtask

  // Called at the negedge of a REQ cycle; returns at the negedge after the handshake.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] instr,
                           input int lat, input int stall, input logic [1:0] op,
                           input logic bt, input logic [31:0] rt,
                           input logic [31:0] exp_next);
    int n;
    bit ok;
    lat_cfg = lat;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (IMemReq) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("req_seen", ok, 1'b1);
    check("req_addr", IMemAddr, addr);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (InstValid) break;
      @(negedge clk);
      n++;
    end
    check("latency", n, lat + 1);
    check("instr", Instruction, instr);
    check("pc_hold", PC, addr);
    check("opcode", Opcode, instr[31:26]);
    check("rs", Rs, instr[25:21]);
    check("rt", Rt, instr[20:16]);
    check("rd", Rd, instr[15:11]);
    check("shamt", Shamt, instr[10:6]);
    check("funct", Funct, instr[5:0]);
    check("imm16", Immediate16, instr[15:0]);
    check("jidx", JumpIndex, instr[25:0]);
    for (int s = 0; s < stall; s++) begin
      InstReady = 1'b0;
      NPCOp     = 2'b11;
      RegTarget = 32'hFFFF_FFFF;
      if (s == 0) spurious = 1'b1;
      @(negedge clk);
      check("stall_valid", InstValid, 1'b1);
      check("stall_noreq", IMemReq, 1'b0);
      check("stall_instr", Instruction, instr);
    end
    NPCOp       = op;
    BranchTaken = bt;
    RegTarget   = rt;
    InstReady   = 1'b1;
    @(negedge clk);
    InstReady   = 1'b0;
    check("hs_valid_drop", InstValid, 1'b0);
    check("next_pc", PC, exp_next);
    if (exp_next[1:0] == 2'b00) begin
      check("next_req", IMemReq, 1'b1);
      check("next_addr", IMemAddr, exp_next);
    end else begin
      check("misaligned_noreq", IMemReq, 1'b0);
    end
  endtask

  initial begin
    InstReady   = 1'b0;
    NPCOp       = 2'b00;
    BranchTaken = 1'b0;
    RegTarget   = 32'h0;
    mem[32'h0000_3000] = 32'h2008_0005;
    mem[32'h0000_3004] = 32'h0800_0C04;
    mem[32'h0000_3010] = 32'h1000_FFFC;
    mem[32'h0000_3014] = 32'h0060_0008;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    check("idle_noreq", IMemReq, 1'b0);
    @(negedge clk);
    check("req_cycle2", IMemReq, 1'b1);
    check("req_cycle2_addr", IMemAddr, 32'h0000_3000);

    // sequential, jump, taken branch, jump, not-taken branch, register jump
    fetch_one(32'h0000_3000, 32'h2008_0005, 1, 0, 2'b00, 1'b0, 32'h0, 32'h0000_3004);
    fetch_one(32'h0000_3004, 32'h0800_0C04, 2, 0, 2'b10, 1'b0, 32'h0, 32'h0000_3010);
    fetch_one(32'h0000_3010, 32'h1000_FFFC, 1, 0, 2'b01, 1'b1, 32'h0, 32'h0000_3004);
    fetch_one(32'h0000_3004, 32'h0800_0C04, 3, 0, 2'b10, 1'b0, 32'h0, 32'h0000_3010);
    fetch_one(32'h0000_3010, 32'h1000_FFFC, 1, 0, 2'b01, 1'b0, 32'h0, 32'h0000_3014);
    fetch_one(32'h0000_3014, 32'h0060_0008, 1, 0, 2'b11, 1'b0, 32'h0000_3002, 32'h0000_3002);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fault_aerr", AddrError, 1'b1);
      check("fault_noreq", IMemReq, 1'b0);
      check("fault_novalid", InstValid, 1'b0);
    end

    rst = 1'b1;
    #1;
    check("fault_rst_pc", PC, 32'h0000_3000);
    check("fault_rst_aerr", AddrError, 1'b0);
    @(negedge clk);
    mem[32'h0000_3000] = 32'h0800_0C10;
    mem[32'h0000_3040] = 32'h2009_0007;
    mem[32'h0000_3044] = 32'h3C01_1234;
    rst = 1'b0;
    @(negedge clk);
    check("restart_req", IMemReq, 1'b1);

    fetch_one(32'h0000_3000, 32'h0800_0C10, 2, 0, 2'b10, 1'b0, 32'h0, 32'h0000_3040);
    fetch_one(32'h0000_3040, 32'h2009_0007, 1, 0, 2'b00, 1'b0, 32'h0, 32'h0000_3044);
    // latency 4, five stalled cycles with a spurious response in HOLD
    fetch_one(32'h0000_3044, 32'h3C01_1234, 4, 5, 2'b00, 1'b0, 32'h0, 32'h0000_3048);

    // async reset while waiting on the response for 0x3048
    @(negedge clk);
    check("wait_state", dbg_state, 3'd2);
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req", IMemReq, 1'b1);
    fetch_one(32'h0000_3000, 32'h0800_0C10, 1, 0, 2'b00, 1'b0, 32'h0, 32'h0000_3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
